// File: rtl/message_stream_demux_pkg.sv
// Framing definitions shared by the message stream combiner and demux:
// header flag position, id/length field placement and FSM state encodings.
package message_stream_demux_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_SKIP    = 2'd2;

  function automatic int hdr_flag_pos(input int wdth);
    return wdth - 1;
  endfunction

  // Stream id field is packed directly below the header flag.
  function automatic int id_msb_pos(input int wdth);
    return wdth - 2;
  endfunction

  function automatic int id_width(input int log_n_streams);
    return log_n_streams;
  endfunction

  function automatic int len_lsb_pos();
    return 0;
  endfunction

  function automatic int len_width(input int log_max_packet_length);
    return log_max_packet_length;
  endfunction

endpackage

// File: rtl/message_stream_demux_header_decode.sv
// Combinational header field extraction for the message stream demux.
module message_header_decode
  import message_stream_demux_pkg::*;
#(
  parameter int WDTH                  = 32,
  parameter int N_STREAMS             = 2,
  parameter int LOG_N_STREAMS         = 1,
  parameter int LOG_MAX_PACKET_LENGTH = 10
) (
  input  logic [WDTH-1:0]                  in_data,
  output logic                             is_header,
  output logic [LOG_N_STREAMS-1:0]         id,
  output logic [LOG_MAX_PACKET_LENGTH-1:0] length,
  output logic                             id_valid
);

  localparam int FLAG_POS = hdr_flag_pos(WDTH);
  localparam int ID_MSB   = id_msb_pos(WDTH);
  localparam int ID_W     = id_width(LOG_N_STREAMS);
  localparam int LEN_LSB  = len_lsb_pos();
  localparam int LEN_W    = len_width(LOG_MAX_PACKET_LENGTH);

  // Bits outside the flag/id/length fields are don't-care.
  logic unused_bits;
  assign unused_bits = ^in_data;

  assign is_header = in_data[FLAG_POS];
  assign id        = in_data[ID_MSB -: ID_W];
  assign length    = in_data[LEN_LSB +: LEN_W];
  assign id_valid  = (int'(id) < N_STREAMS);

endmodule

// File: rtl/message_stream_demux.sv
// Steers framed payload words to one of N_STREAMS channels by header id.
// Define MESSAGE_STREAM_DEMUX_STICKY_ERROR_EN to make error latch until reset.
module message_stream_demux
  import message_stream_demux_pkg::*;
#(
  parameter int WDTH                  = 32,
  parameter int N_STREAMS             = 2,
  parameter int LOG_N_STREAMS         = 1,
  parameter int LOG_MAX_PACKET_LENGTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WDTH-1:0]      in_data,
  input  logic                 in_nd,
  output logic [WDTH-1:0]      out_data,
  output logic [N_STREAMS-1:0] out_nd,
  output logic                 error
);

  localparam logic [LOG_MAX_PACKET_LENGTH-1:0] CNT_ONE  = LOG_MAX_PACKET_LENGTH'(1);
  localparam logic [LOG_MAX_PACKET_LENGTH-1:0] CNT_ZERO = '0;

  logic                             hdr_is_header;
  logic [LOG_N_STREAMS-1:0]         hdr_id;
  logic [LOG_MAX_PACKET_LENGTH-1:0] hdr_length;
  logic                             hdr_id_valid;

  message_header_decode #(
    .WDTH                 (WDTH),
    .N_STREAMS            (N_STREAMS),
    .LOG_N_STREAMS        (LOG_N_STREAMS),
    .LOG_MAX_PACKET_LENGTH(LOG_MAX_PACKET_LENGTH)
  ) u_header_decode (
    .in_data  (in_data),
    .is_header(hdr_is_header),
    .id       (hdr_id),
    .length   (hdr_length),
    .id_valid (hdr_id_valid)
  );

  logic [1:0]                       state_q, state_d;
  logic [LOG_MAX_PACKET_LENGTH-1:0] count_q, count_d;
  logic [LOG_N_STREAMS-1:0]         id_q, id_d;
  logic [WDTH-1:0]                  out_data_q, out_data_d;
  logic [N_STREAMS-1:0]             out_nd_q, out_nd_d;
  logic                             error_q, error_d;
  logic                             err_now;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    id_d       = id_q;
    out_data_d = out_data_q;
    out_nd_d   = '0;
    err_now    = 1'b0;
    if (in_nd) begin
      if (hdr_is_header) begin
        // A header outside IDLE truncates the current packet; resync on it.
        if (state_q != ST_IDLE) err_now = 1'b1;
        if (!hdr_id_valid) err_now = 1'b1;
        if (hdr_length == CNT_ZERO) begin
          state_d = ST_IDLE;
          count_d = CNT_ZERO;
        end else if (hdr_id_valid) begin
          state_d = ST_PAYLOAD;
          count_d = hdr_length;
          id_d    = hdr_id;
        end else begin
          state_d = ST_SKIP;
          count_d = hdr_length;
        end
      end else begin
        case (state_q)
          ST_PAYLOAD: begin
            out_data_d = in_data;
            for (int k = 0; k < N_STREAMS; k++) begin
              out_nd_d[k] = (id_q == LOG_N_STREAMS'(k));
            end
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) state_d = ST_IDLE;
          end
          ST_SKIP: begin
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) state_d = ST_IDLE;
          end
          default: begin
            err_now = 1'b1;
            state_d = ST_IDLE;
          end
        endcase
      end
    end
`ifdef MESSAGE_STREAM_DEMUX_STICKY_ERROR_EN
    error_d = error_q | err_now;
`else
    error_d = err_now;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      id_q       <= '0;
      out_data_q <= '0;
      out_nd_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      id_q       <= id_d;
      out_data_q <= out_data_d;
      out_nd_q   <= out_nd_d;
      error_q    <= error_d;
    end
  end

  assign out_data = out_data_q;
  assign out_nd   = out_nd_q;
  assign error    = error_q;

endmodule

// File: doc/message_stream_demux.md
Name: message_stream_demux

Overview:
- Receive-side counterpart of the message stream combiner: takes one framed stream of header and payload words and steers each packet's payload to one of N_STREAMS output channels, selected by the stream id in the header.
- Sits downstream of a combined link, e.g. after the combiner in a loopback bench or at the far end of an FPGA data path.
- Detects and flags framing violations.

Parameters:
- WDTH, 32, word width of input and output data.
- N_STREAMS, 2, number of output channels.
- LOG_N_STREAMS, 1, width of the stream id field; must satisfy 2**LOG_N_STREAMS >= N_STREAMS.
- LOG_MAX_PACKET_LENGTH, 10, width of the header length field.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  WDTH  combined stream word.
- in_nd  input  1  in_data valid this cycle.
- out_data  output  WDTH  payload word, shared by all channels.
- out_nd  output  N_STREAMS  one-hot valid; bit k set means out_data belongs to stream k.
- error  output  1  framing error indication.

Behaviour:
- Word format:
  - Header: bit WDTH-1 = 1; bits [WDTH-2 -: LOG_N_STREAMS] = stream id; bits [LOG_MAX_PACKET_LENGTH-1:0] = payload length L. All other bits are ignored.
  - Payload word: bit WDTH-1 = 0. It is forwarded unchanged.
- Single clock. Reset is synchronous and active-low: on clk rising edge with rst_n=0, out_data=0, out_nd=0, error=0, state=IDLE, remaining count=0, stored id=0.
- Only cycles with in_nd=1 advance state. Gaps of any length are allowed anywhere, and state holds through them.
- All outputs are registered. Latency is 1 cycle from an accepted in_data word to out_data/out_nd.
- out_nd is all-zero on any cycle without a forwarded payload word. At most one out_nd bit is ever set.
- FSM:
  - IDLE:
    - Header with id < N_STREAMS and L>0: store id, load count=L, go to PAYLOAD.
    - Header with L=0: stay in IDLE, no output, no error.
    - Header with id >= N_STREAMS: error, load count=L, go to SKIP (or stay in IDLE if L=0).
    - Payload word: error, word dropped.
  - PAYLOAD:
    - Payload word: forward with out_nd[id]=1 and decrement count; go to IDLE when count reaches 0.
    - Header word: error; the truncated packet is abandoned and the new header is processed as in IDLE in the same cycle (resync).
  - SKIP:
    - Payload word: decrement count with no output; go to IDLE at 0.
    - Header word: error plus resync, as in PAYLOAD.
- error is a 1-cycle pulse, registered, aligned with the output cycle of the offending word.
- Reset mid-packet discards the remainder. Subsequent orphan payload words raise error in IDLE.
- Count width is LOG_MAX_PACKET_LENGTH. The maximum packet is 2**LOG_MAX_PACKET_LENGTH-1 words, and the count never wraps.

Optional Feature:
- Macro MESSAGE_STREAM_DEMUX_STICKY_ERROR_EN.
- Defined: error latches high on the first violation and stays high until reset.
- Undefined: error is the 1-cycle pulse described above.
- Data path behaviour is identical in both cases.

Decomposition:
- Shared package/header holds:
  - header flag bit position;
  - field offset/width macros for stream id and length;
  - the FSM state encodings IDLE/PAYLOAD/SKIP.
- These are shared with the combiner so both ends agree on the framing.
- One sub-module, message_header_decode (combinational): in_data -> is_header, id, length, id_valid. The FSM and counter stay in the top.

Test Plan:
- WDTH=32, N_STREAMS=2. Send 0xC0000003, 0x11, 0x22, 0x33 -> three cycles of out_nd=2'b10 with out_data 0x11, 0x22, 0x33; error never set.
- Send 0x80000002, 0x05, then an in_nd gap of 5 cycles, then 0x06 -> out_nd=2'b01 for 0x05 and 0x06 only; no output during the gap.
- Send 0x80000000, then 0xC0000001, 0x07 -> nothing for the empty packet; out_nd=2'b10 with 0x07; no error.
- Send 0x80000003, 0x01, then 0xC0000001, 0x09 -> 0x01 on stream 0; error pulse on the header cycle; 0x09 on stream 1 (resync).
- Send an orphan 0x00000042 after reset -> error=1 for one cycle and out_nd=0. Repeat with STICKY_ERROR_EN defined -> error stays 1 until rst_n=0.
- Send 0x80000004, 0x01, assert rst_n=0 for 1 cycle, then send 0x02 -> all outputs 0 after reset; 0x02 raises error and is not forwarded.
